pnl_link_slave: RTL and testbench



---
 rtl/pnl_pkg.sv | 26 ++
 rtl/pnl_sync.sv | 31 +++
 rtl/pnl_link_slave.sv | 218 +++++++++++++++++++++
 tb/tb_pnl_link_slave.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pnl_pkg.sv
// Shared definitions for the panel link slave: register map, CTRL bit
// positions, link FSM states and frame-length helper.
package pnl_pkg;

  localparam logic [3:0] REG_CTRL  = 4'd0;
  localparam logic [3:0] REG_ADDR  = 4'd1;
  localparam logic [3:0] REG_DATA0 = 4'd2;

  localparam int CTRL_SEND_STA   = 0;
  localparam int CTRL_RECV_STA   = 1;
  localparam int CTRL_IRQ_EN     = 2;
  localparam int CTRL_FRAME_DONE = 3;
  localparam int CTRL_OVERRUN    = 4;
  localparam int CTRL_SHORT_ERR  = 5;

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } link_state_e;

  // Status frames carry one status bit followed by the address; data frames carry whole bytes.
  function automatic int frame_len(input logic is_sta, input int data_bytes, input int addr_w);
    return is_sta ? (1 + addr_w) : (8 * data_bytes);
  endfunction

endpackage

// File: rtl/pnl_sync.sv
// Multi-flop synchroniser for one panel pin, with single-cycle rise/fall
// pulses derived from the synchronised level.
module pnl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/pnl_link_slave.sv
// Avalon-MM slave bridging the CPU to an external panel master over the
// PNL_* serial link, with double-buffered tx/rx registers and a maskable irq.
module pnl_link_slave
  import pnl_pkg::*;
#(
  parameter int DATA_BYTES  = 4,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       csi_clockreset_clk,
  input  logic       csi_clockreset_reset_n,
  input  logic [3:0] avs_address,
  input  logic       avs_read_n,
  input  logic       avs_write_n,
  input  logic [7:0] avs_writedata,
  output logic [7:0] avs_readdata,
  output logic       avs_waitrequest_n,
  output logic       ins_event_irq,
  output logic       PNL_DO,
  input  logic       PNL_DI,
  input  logic       PNL_CLK,
  input  logic       PNL_LE,
  input  logic       PNL_STA
);

  localparam int STA_LEN = frame_len(1'b1, DATA_BYTES, ADDR_W);
  localparam int DAT_LEN = frame_len(1'b0, DATA_BYTES, ADDR_W);
  localparam int BUF_W   = 8 * DATA_BYTES;
  localparam int TX_W    = (STA_LEN > DAT_LEN) ? STA_LEN : DAT_LEN;
  localparam int CNT_W   = $clog2(TX_W + 1);
  localparam int IDX_W   = $clog2(TX_W);

  localparam logic [CNT_W-1:0] STA_LEN_C = CNT_W'(STA_LEN);
  localparam logic [CNT_W-1:0] DAT_LEN_C = CNT_W'(DAT_LEN);

  logic clk;
  logic rst_n;
  assign clk   = csi_clockreset_clk;
  assign rst_n = csi_clockreset_reset_n;

  logic di_s, sta_s, pclk_s, le_s;
  logic pclk_rise, le_rise, le_fall;
  logic unused_di_rise, unused_di_fall, unused_sta_rise, unused_sta_fall;
  logic unused_pclk_fall, unused_pclk_lvl, unused_le_lvl;

  pnl_sync #(.STAGES(SYNC_STAGES)) u_sync_di (
    .clk_i(clk), .rst_ni(rst_n), .d_i(PNL_DI),
    .q_o(di_s), .rise_o(unused_di_rise), .fall_o(unused_di_fall)
  );
  pnl_sync #(.STAGES(SYNC_STAGES)) u_sync_sta (
    .clk_i(clk), .rst_ni(rst_n), .d_i(PNL_STA),
    .q_o(sta_s), .rise_o(unused_sta_rise), .fall_o(unused_sta_fall)
  );
  pnl_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk_i(clk), .rst_ni(rst_n), .d_i(PNL_CLK),
    .q_o(pclk_s), .rise_o(pclk_rise), .fall_o(unused_pclk_fall)
  );
  pnl_sync #(.STAGES(SYNC_STAGES)) u_sync_le (
    .clk_i(clk), .rst_ni(rst_n), .d_i(PNL_LE),
    .q_o(le_s), .rise_o(le_rise), .fall_o(le_fall)
  );
  assign unused_pclk_lvl = pclk_s;
  assign unused_le_lvl   = le_s;

  link_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TX_W-1:0]    tx_q, tx_d;
  logic [TX_W-1:0]    rx_q, rx_d;
  logic               is_sta_q, is_sta_d;
  logic               send_sta_q, send_sta_d;
  logic [ADDR_W-1:0]  send_add_q, send_add_d;
  logic [BUF_W-1:0]   send_buf_q, send_buf_d;
  logic               recv_sta_q, recv_sta_d;
  logic [ADDR_W-1:0]  recv_add_q, recv_add_d;
  logic [BUF_W-1:0]   recv_buf_q, recv_buf_d;
  logic               irq_en_q, irq_en_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;
  logic               short_err_q, short_err_d;
  logic               irq_q;
  logic [CNT_W-1:0]   cur_len;

  assign cur_len = is_sta_q ? STA_LEN_C : DAT_LEN_C;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    is_sta_d     = is_sta_q;
    send_sta_d   = send_sta_q;
    send_add_d   = send_add_q;
    send_buf_d   = send_buf_q;
    recv_sta_d   = recv_sta_q;
    recv_add_d   = recv_add_q;
    recv_buf_d   = recv_buf_q;
    irq_en_d     = irq_en_q;
    frame_done_d = frame_done_q;
    overrun_d    = overrun_q;
    short_err_d  = short_err_q;

    // CPU side first so that a same-cycle flag set below overrides a w1c.
    if (!avs_write_n) begin
      if (avs_address == REG_CTRL) begin
        send_sta_d = avs_writedata[CTRL_SEND_STA];
        irq_en_d   = avs_writedata[CTRL_IRQ_EN];
        if (avs_writedata[CTRL_FRAME_DONE]) frame_done_d = 1'b0;
        if (avs_writedata[CTRL_OVERRUN])    overrun_d    = 1'b0;
        if (avs_writedata[CTRL_SHORT_ERR])  short_err_d  = 1'b0;
      end else if (avs_address == REG_ADDR) begin
        send_add_d = avs_writedata[ADDR_W-1:0];
      end else begin
        for (int i = 0; i < DATA_BYTES; i++) begin
          if (avs_address == REG_DATA0 + 4'(i)) send_buf_d[8*i +: 8] = avs_writedata;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (le_fall) begin
          state_d  = ST_FRAME;
          is_sta_d = sta_s;
          cnt_d    = '0;
          rx_d     = '0;
          tx_d     = sta_s ? TX_W'({send_add_q, send_sta_q}) : TX_W'(send_buf_q);
        end
      end
      ST_FRAME: begin
        if (le_rise) begin
          state_d = ST_IDLE;
          tx_d    = '0;
          if (cnt_q == cur_len) begin
            if (is_sta_q) begin
              recv_sta_d = rx_q[0];
              recv_add_d = rx_q[ADDR_W:1];
            end else begin
              recv_buf_d = rx_q[BUF_W-1:0];
            end
            if (frame_done_q) overrun_d = 1'b1;
            frame_done_d = 1'b1;
          end else begin
            short_err_d = 1'b1;
          end
        end else if (pclk_rise && (cnt_q < cur_len)) begin
          // tx shadow is zero-padded above the frame length, so DO falls to 0 once exhausted.
          rx_d[cnt_q[IDX_W-1:0]] = di_s;
          cnt_d = cnt_q + CNT_W'(1);
          tx_d  = tx_q >> 1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      is_sta_q     <= 1'b0;
      send_sta_q   <= 1'b0;
      send_add_q   <= '0;
      send_buf_q   <= '0;
      recv_sta_q   <= 1'b0;
      recv_add_q   <= '0;
      recv_buf_q   <= '0;
      irq_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      short_err_q  <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      is_sta_q     <= is_sta_d;
      send_sta_q   <= send_sta_d;
      send_add_q   <= send_add_d;
      send_buf_q   <= send_buf_d;
      recv_sta_q   <= recv_sta_d;
      recv_add_q   <= recv_add_d;
      recv_buf_q   <= recv_buf_d;
      irq_en_q     <= irq_en_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      short_err_q  <= short_err_d;
      irq_q        <= irq_en_q & (frame_done_q | overrun_q | short_err_q);
    end
  end

  always_comb begin
    avs_readdata = '0;
    if (!avs_read_n) begin
      if (avs_address == REG_CTRL) begin
        avs_readdata[CTRL_SEND_STA]   = send_sta_q;
        avs_readdata[CTRL_RECV_STA]   = recv_sta_q;
        avs_readdata[CTRL_IRQ_EN]     = irq_en_q;
        avs_readdata[CTRL_FRAME_DONE] = frame_done_q;
        avs_readdata[CTRL_OVERRUN]    = overrun_q;
        avs_readdata[CTRL_SHORT_ERR]  = short_err_q;
      end else if (avs_address == REG_ADDR) begin
        avs_readdata = 8'(recv_add_q);
      end else begin
        for (int i = 0; i < DATA_BYTES; i++) begin
          if (avs_address == REG_DATA0 + 4'(i)) avs_readdata = recv_buf_q[8*i +: 8];
        end
      end
    end
  end

  assign avs_waitrequest_n = 1'b1;
  assign ins_event_irq     = irq_q;
  assign PNL_DO            = tx_q[0];

endmodule

// File: tb/tb_pnl_link_slave.sv
// Directed bench for pnl_link_slave: register-map vector table plus
// hand-written frame sequences for the multi-cycle corner cases.
module tb_pnl_link_slave;

  logic       clk;
  logic       rst_n;
  logic [3:0] avs_address;
  logic       avs_read_n;
  logic       avs_write_n;
  logic [7:0] avs_writedata;
  logic [7:0] avs_readdata;
  logic       avs_waitrequest_n;
  logic       ins_event_irq;
  logic       pnl_do;
  logic       pnl_di;
  logic       pnl_clk;
  logic       pnl_le;
  logic       pnl_sta;

  int total = 0;
  int bad   = 0;
  logic [63:0] do_cap;

  pnl_link_slave dut (
    .csi_clockreset_clk     (clk),
    .csi_clockreset_reset_n (rst_n),
    .avs_address            (avs_address),
    .avs_read_n             (avs_read_n),
    .avs_write_n            (avs_write_n),
    .avs_writedata          (avs_writedata),
    .avs_readdata           (avs_readdata),
    .avs_waitrequest_n      (avs_waitrequest_n),
    .ins_event_irq          (ins_event_irq),
    .PNL_DO                 (pnl_do),
    .PNL_DI                 (pnl_di),
    .PNL_CLK                (pnl_clk),
    .PNL_LE                 (pnl_le),
    .PNL_STA                (pnl_sta)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [0:15];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver tasks
  task automatic cpu_write(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    avs_address   = addr;
    avs_writedata = data;
    avs_write_n   = 1'b0;
    @(negedge clk);
    avs_write_n   = 1'b1;
  endtask

  task automatic cpu_read(input logic [3:0] addr, output logic [7:0] data);
    @(negedge clk);
    avs_address = addr;
    avs_read_n  = 1'b0;
    #1;
    data = avs_readdata;
    avs_read_n  = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    cpu_read(addr, d);
    check(name, 64'(d), 64'(exp));
  endtask

  task automatic le_fall(input logic sta);
    @(negedge clk);
    pnl_sta = sta;
    pnl_le  = 1'b0;
    do_cap  = '0;
    wait_cyc(8);
  endtask

  // DO is captured at the end of each low phase, i.e. the bit presented before that rise.
  task automatic clk_bits(input int first, input int n, input logic [63:0] di);
    for (int i = first; i < first + n; i++) begin
      pnl_di = di[i];
      wait_cyc(8);
      do_cap[i] = pnl_do;
      pnl_clk = 1'b1;
      wait_cyc(8);
      pnl_clk = 1'b0;
    end
  endtask

  task automatic le_rise();
    wait_cyc(8);
    pnl_le = 1'b1;
    wait_cyc(8);
  endtask

  task automatic full_frame(input logic sta, input int n, input logic [63:0] di);
    le_fall(sta);
    clk_bits(0, n, di);
    le_rise();
  endtask

  initial begin
    rst_n = 1'b0; avs_address = '0; avs_read_n = 1'b1; avs_write_n = 1'b1;
    avs_writedata = '0; pnl_di = 1'b0; pnl_clk = 1'b0; pnl_le = 1'b1; pnl_sta = 1'b0;
    do_cap = '0;

    vecs[0]  = '{1'b0, 4'd0,  8'h00, 8'h00};
    vecs[1]  = '{1'b0, 4'd1,  8'h00, 8'h00};
    vecs[2]  = '{1'b0, 4'd2,  8'h00, 8'h00};
    vecs[3]  = '{1'b0, 4'd5,  8'h00, 8'h00};
    vecs[4]  = '{1'b0, 4'd6,  8'h00, 8'h00};
    vecs[5]  = '{1'b0, 4'd15, 8'h00, 8'h00};
    vecs[6]  = '{1'b1, 4'd0,  8'hFF, 8'h00};
    vecs[7]  = '{1'b0, 4'd0,  8'h00, 8'h05};
    vecs[8]  = '{1'b1, 4'd1,  8'h3C, 8'h00};
    vecs[9]  = '{1'b0, 4'd1,  8'h00, 8'h00};
    vecs[10] = '{1'b1, 4'd6,  8'hAA, 8'h00};
    vecs[11] = '{1'b0, 4'd6,  8'h00, 8'h00};
    vecs[12] = '{1'b1, 4'd0,  8'h00, 8'h00};
    vecs[13] = '{1'b0, 4'd0,  8'h00, 8'h00};
    vecs[14] = '{1'b1, 4'd2,  8'h78, 8'h00};
    vecs[15] = '{1'b0, 4'd2,  8'h00, 8'h00};

    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(8);
    check("reset_do", 64'(pnl_do), 64'd0);
    check("reset_irq", 64'(ins_event_irq), 64'd0);
    check("waitrequest_n", 64'(avs_waitrequest_n), 64'd1);

    for (int v = 0; v < 16; v++) begin
      if (vecs[v].wr) cpu_write(vecs[v].addr, vecs[v].data);
      else rd_chk($sformatf("vec%0d_addr%0d", v, vecs[v].addr), vecs[v].addr, vecs[v].exp);
    end

    // data frame
    cpu_write(4'd2, 8'h78); cpu_write(4'd3, 8'h56);
    cpu_write(4'd4, 8'h34); cpu_write(4'd5, 8'h12);
    full_frame(1'b0, 32, 64'hA5C3_0F81);
    check("data_do", do_cap[31:0], 64'h1234_5678);
    rd_chk("data_rd0", 4'd2, 8'h81);
    rd_chk("data_rd1", 4'd3, 8'h0F);
    rd_chk("data_rd2", 4'd4, 8'hC3);
    rd_chk("data_rd3", 4'd5, 8'hA5);
    rd_chk("data_ctrl", 4'd0, 8'h08);
    check("data_irq_masked", 64'(ins_event_irq), 64'd0);
    cpu_write(4'd0, 8'h08);
    rd_chk("data_w1c", 4'd0, 8'h00);

    // status frame
    cpu_write(4'd0, 8'h01);
    full_frame(1'b1, 9, 64'h12D);
    check("sta_do", do_cap[8:0], 64'h079);
    rd_chk("sta_ctrl", 4'd0, 8'h0B);
    rd_chk("sta_addr", 4'd1, 8'h96);
    rd_chk("sta_buf_kept", 4'd2, 8'h81);
    cpu_write(4'd0, 8'h08);
    rd_chk("sta_w1c", 4'd0, 8'h02);

    // short frame
    full_frame(1'b0, 10, 64'hFFFF_FFFF);
    rd_chk("short_ctrl", 4'd0, 8'h22);
    rd_chk("short_buf0", 4'd2, 8'h81);
    rd_chk("short_buf1", 4'd3, 8'h0F);
    check("short_irq_masked", 64'(ins_event_irq), 64'd0);
    cpu_write(4'd0, 8'h04);
    wait_cyc(2);
    check("short_irq_on", 64'(ins_event_irq), 64'd1);
    rd_chk("short_ctrl_en", 4'd0, 8'h26);
    cpu_write(4'd0, 8'h24);
    wait_cyc(2);
    check("short_irq_off", 64'(ins_event_irq), 64'd0);
    rd_chk("short_w1c", 4'd0, 8'h06);
    cpu_write(4'd0, 8'h00);

    // overrun, then w1c landing on the commit cycle
    full_frame(1'b0, 32, 64'h1122_3344);
    rd_chk("ovr_first", 4'd0, 8'h0A);
    full_frame(1'b0, 32, 64'h5566_7788);
    rd_chk("ovr_ctrl", 4'd0, 8'h1A);
    rd_chk("ovr_rd0", 4'd2, 8'h88);
    rd_chk("ovr_rd3", 4'd5, 8'h55);
    le_fall(1'b0);
    clk_bits(0, 32, 64'h0BAD_F00D);
    wait_cyc(8);
    pnl_le = 1'b1;
    wait_cyc(2);
    avs_address = 4'd0; avs_writedata = 8'h18; avs_write_n = 1'b0;
    @(negedge clk);
    avs_write_n = 1'b1;
    wait_cyc(4);
    rd_chk("coinc_ctrl", 4'd0, 8'h1A);
    rd_chk("coinc_rd0", 4'd2, 8'h0D);
    rd_chk("coinc_rd3", 4'd5, 8'h0B);
    cpu_write(4'd0, 8'h18);
    rd_chk("coinc_clear", 4'd0, 8'h02);

    // mid-frame CPU write only affects the next frame
    le_fall(1'b0);
    clk_bits(0, 8, 64'd0);
    cpu_write(4'd2, 8'hFF);
    clk_bits(8, 24, 64'd0);
    le_rise();
    check("midw_do_cur", do_cap[31:0], 64'h1234_5678);
    full_frame(1'b0, 32, 64'd0);
    check("midw_do_next", do_cap[31:0], 64'h1234_56FF);
    rd_chk("midw_rd0", 4'd2, 8'h00);

    // reset in the middle of a frame
    le_fall(1'b0);
    clk_bits(0, 17, 64'hFFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    check("rst_do", 64'(pnl_do), 64'd0);
    check("rst_irq", 64'(ins_event_irq), 64'd0);
    rd_chk("rst_ctrl", 4'd0, 8'h00);
    rd_chk("rst_addr", 4'd1, 8'h00);
    for (int b = 0; b < 4; b++) rd_chk($sformatf("rst_data%0d", b), 4'(2 + b), 8'h00);
    wait_cyc(8);
    pnl_le = 1'b1;
    wait_cyc(8);
    rd_chk("rst_le_idle", 4'd0, 8'h00);
    full_frame(1'b0, 32, 64'hCAFE_BABE);
    check("post_rst_do", do_cap[31:0], 64'd0);
    rd_chk("post_rst_rd0", 4'd2, 8'hBE);
    rd_chk("post_rst_rd1", 4'd3, 8'hBA);
    rd_chk("post_rst_rd2", 4'd4, 8'hFE);
    rd_chk("post_rst_rd3", 4'd5, 8'hCA);
    rd_chk("post_rst_ctrl", 4'd0, 8'h08);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
